result_port_checker: RTL

//  Parametrised self-check monitor on the CPU data-memory write bus (L2-cache system benches).

---
 rtl/checker_pkg.sv | 33 +++
 rtl/result_port_checker_if.sv | 22 ++
 rtl/check_table_ram.sv | 33 +++
 rtl/result_port_checker.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/checker_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : checker_pkg
//  Description : Shared types, default symbols and the byte-swap helper for
//                the result port checker.
//  Revision    : 1.0 - initial release
// ============================================================================
package checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CHECK   = 2'd1,
        ST_REPORT  = 2'd2,
        ST_TIMEOUT = 2'd3
    } state_t;

    localparam logic [31:0] c_BEGIN_SYM_DEF = 32'h0000_0168;
    localparam logic [31:0] c_END_SYM_DEF   = 32'hFFFF_FD5D;

    // Reverse the order of the lowest nbytes bytes of d (up to 32 bytes).
    function automatic logic [255:0] byte_swap(input logic [255:0] d, input int nbytes);
        logic [255:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < nbytes) begin
                r[8*i +: 8] = d[8*(nbytes-1-i) +: 8];
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/result_port_checker_if.sv
`default_nettype none
// ============================================================================
//  Module      : result_port_checker_if
//  Description : Data-memory write bus plus expected-table load port.
//  Revision    : 1.0 - initial release
// ============================================================================
interface result_port_checker_if #(
    parameter int ADDR_W = 30,
    parameter int DATA_W = 32,
    parameter int IDX_W  = 8
);
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              wen;
    logic              exp_we;
    logic [IDX_W-1:0]  exp_idx;
    logic [DATA_W-1:0] exp_data;

    modport master (output addr, data, wen, exp_we, exp_idx, exp_data);
    modport slave  (input  addr, data, wen, exp_we, exp_idx, exp_data);
endinterface
`default_nettype wire

// File: rtl/check_table_ram.sv
`default_nettype none
// ============================================================================
//  Module      : check_table_ram
//  Description : Expected-value table, one write port, one async read port.
//                Contents are deliberately not reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module check_table_ram #(
    parameter int DEPTH  = 160,
    parameter int DATA_W = 32,
    parameter int IDX_W  = 8
) (
    input  wire logic              clk,
    input  wire logic              i_we,
    input  wire logic [IDX_W-1:0]  i_waddr,
    input  wire logic [DATA_W-1:0] i_wdata,
    input  wire logic [IDX_W-1:0]  i_raddr,
    output logic      [DATA_W-1:0] o_rdata
);
    localparam logic [IDX_W-1:0] c_DEPTH = IDX_W'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Table write; out-of-range indices are dropped.
    always_ff @(posedge clk) begin
        if (i_we && (i_waddr < c_DEPTH)) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = (i_raddr < c_DEPTH) ? r_mem[i_raddr] : '0;
endmodule
`default_nettype wire

// File: rtl/result_port_checker.sv
`default_nettype none
// ============================================================================
//  Module      : result_port_checker
//  Description : Self-check monitor on the data-memory write bus. Arms on a
//                begin symbol, compares subsequent test-port writes against a
//                loadable table plus a fixed end symbol, reports the result.
//  Revision    : 1.0 - initial release
// ============================================================================
module result_port_checker
    import checker_pkg::*;
#(
    parameter int                ADDR_W     = 30,
    parameter int                DATA_W     = 32,
    parameter logic [ADDR_W-1:0] TEST_PORT  = 30'h3FF,
    parameter logic [DATA_W-1:0] BEGIN_SYM  = DATA_W'(c_BEGIN_SYM_DEF),
    parameter logic [DATA_W-1:0] END_SYM    = DATA_W'(c_END_SYM_DEF),
    parameter int                CHECK_NUM  = 161,
    parameter int                SWAP_BYTES = 1,
    parameter int                ERR_W      = 8,
    parameter int                DUR_W      = 16,
    parameter logic [DUR_W-1:0]  TIMEOUT    = 16'hFFFF,
    localparam int               IDX_W      = $clog2(CHECK_NUM + 1)
) (
    input  wire logic               clk,
    input  wire logic               rst,
    result_port_checker_if.slave    bus,
    output logic      [ERR_W-1:0]   error_num,
    output logic      [DUR_W-1:0]   duration,
    output logic                    finish,
    output logic                    timeout,
    output logic                    first_err_vld,
    output logic      [IDX_W-1:0]   first_err_idx
);
    localparam logic [IDX_W-1:0] c_LAST     = IDX_W'(CHECK_NUM - 1);
    localparam logic [ERR_W-1:0] c_ERR_IDLE = '1;
    localparam logic [ERR_W-1:0] c_ERR_SAT  = c_ERR_IDLE - 1'b1;
    localparam logic [DUR_W-1:0] c_DUR_MAX  = '1;
    localparam logic [DUR_W-1:0] c_TO_LAST  = TIMEOUT - 1'b1;

    state_t            r_state, w_next;
    logic              r_wen_q;
    logic [IDX_W-1:0]  r_idx;
    logic [ERR_W-1:0]  r_err;
    logic [DUR_W-1:0]  r_dur;
    logic              r_fin, r_to, r_fev;
    logic [IDX_W-1:0]  r_fei;
    logic [DATA_W-1:0] w_dmod, w_exp, w_tbl_rd;
    logic              w_acc, w_final, w_to_hit, w_tbl_we, w_begin;

    generate
        if (SWAP_BYTES != 0) begin : g_swap
            assign w_dmod = DATA_W'(byte_swap(256'(bus.data), DATA_W / 8));
        end else begin : g_noswap
            assign w_dmod = bus.data;
        end
    endgenerate

    // Rising edge of wen only, so stall repeats count once.
    assign w_acc    = bus.wen & ~r_wen_q & (bus.addr == TEST_PORT);
    assign w_begin  = w_acc & (w_dmod == BEGIN_SYM);
    assign w_final  = w_acc & (r_idx == c_LAST);
    assign w_to_hit = (TIMEOUT != '0) && (r_dur == c_TO_LAST);
    assign w_exp    = (r_idx == c_LAST) ? END_SYM : w_tbl_rd;
    assign w_tbl_we = bus.exp_we & (r_state == ST_IDLE) & (bus.exp_idx < c_LAST);

    check_table_ram #(
        .DEPTH  (CHECK_NUM - 1),
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_table (
        .clk     (clk),
        .i_we    (w_tbl_we),
        .i_waddr (bus.exp_idx),
        .i_wdata (bus.exp_data),
        .i_raddr (r_idx),
        .o_rdata (w_tbl_rd)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    // Next state; the final write takes priority over the timeout.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_begin) w_next = ST_CHECK;
            ST_CHECK: begin
                if (w_final)       w_next = ST_REPORT;
                else if (w_to_hit) w_next = ST_TIMEOUT;
            end
            default:  w_next = r_state;
        endcase
    end

    // Counters, status flags and first-error capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wen_q <= 1'b0;
            r_idx   <= '0;
            r_err   <= c_ERR_IDLE;
            r_dur   <= '0;
            r_fin   <= 1'b0;
            r_to    <= 1'b0;
            r_fev   <= 1'b0;
            r_fei   <= '0;
        end else begin
            r_wen_q <= bus.wen;
            r_fin   <= (w_next == ST_REPORT) || (w_next == ST_TIMEOUT);
            r_to    <= (w_next == ST_TIMEOUT);
            case (r_state)
                ST_IDLE: begin
                    if (w_begin) begin
                        r_err <= '0;
                        r_idx <= '0;
                        r_dur <= '0;
                        r_fev <= 1'b0;
                    end
                end
                ST_CHECK: begin
                    if (r_dur != c_DUR_MAX) r_dur <= r_dur + 1'b1;
                    if (w_acc) begin
                        r_idx <= r_idx + 1'b1;
                        if (w_dmod != w_exp) begin
                            if (r_err < c_ERR_SAT) r_err <= r_err + 1'b1;
                            if (!r_fev) begin
                                r_fei <= r_idx;
                                r_fev <= 1'b1;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign error_num     = r_err;
    assign duration      = r_dur;
    assign finish        = r_fin;
    assign timeout       = r_to;
    assign first_err_vld = r_fev;
    assign first_err_idx = r_fei;
endmodule
`default_nettype wire
